// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: sequential, branch, jump and exception redirects with a fetch handshake.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets trap to EXC_VECTOR and pulse misalign.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        jmp_en,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    // state  | meaning
    // BOOT   | reset vector loaded, no request yet
    // RUN    | pc presented as a fetch request
    // HOLD   | pipeline stalled, request still visible
    // BUBBLE | one idle cycle after a redirect
    typedef enum logic [1:0] {BOOT, RUN, HOLD, BUBBLE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic        accept;
    logic [31:0] sel_target;
    logic [31:0] redir_pc;
    logic        bad_align;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            count_q    <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign redirect   = exc_req | jmp_en | br_taken;
    assign accept     = fetch_valid & fetch_ready & ~stall;
    assign sel_target = jmp_en ? jmp_target : br_target;

`ifdef PC_ALIGN_CHECK_EN
    assign bad_align = ~exc_req & (sel_target[1:0] != 2'b00);
    assign redir_pc  = (exc_req | bad_align) ? EXC_VECTOR : sel_target;
`else
    assign bad_align = 1'b0;
    assign redir_pc  = exc_req ? EXC_VECTOR : (sel_target & ~32'h3);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, HOLD: begin
                // A redirect never blocks counting of a fetch accepted in the same cycle.
                if (accept)
                    count_d = count_q + 32'd1;
                if (redirect) begin
                    pc_d       = redir_pc;
                    flush_d    = 1'b1;
                    misalign_d = bad_align;
                    state_d    = BUBBLE;
                end else if (accept) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = RUN;
                end else if (stall) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            BUBBLE: begin
                if (redirect) begin
                    pc_d       = redir_pc;
                    flush_d    = 1'b1;
                    misalign_d = bad_align;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state_q == RUN) || (state_q == HOLD);
        pc          = pc_q;
        fetch_count = count_q;
        flush       = flush_q;
        misalign    = misalign_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expected values are hand-derived per step.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        stall;
    logic        exc_req;
    logic        jmp_en;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic        misalign;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .stall       (stall),
        .exc_req     (exc_req),
        .jmp_en      (jmp_en),
        .jmp_target  (jmp_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .flush       (flush),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] e_pc, input logic e_fv,
                             input logic e_fl, input logic e_mis, input logic [31:0] e_cnt);
        check({tag, ".pc"},    pc,                  e_pc);
        check({tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, e_fv});
        check({tag, ".flush"}, {31'd0, flush},       {31'd0, e_fl});
        check({tag, ".mis"},   {31'd0, misalign},    {31'd0, e_mis});
        check({tag, ".cnt"},   fetch_count,         e_cnt);
    endtask

    initial begin
        rst = 1'b1; fetch_ready = 1'b1; stall = 1'b0;
        exc_req = 1'b0; jmp_en = 1'b0; br_taken = 1'b0;
        jmp_target = '0; br_target = '0;

        tick();
        check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        tick();
        check_out("run0", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(); check_out("run4", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
        tick(); check_out("run8", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
        tick(); check_out("runC", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);
        tick(); check_out("run10", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);

        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_out("bp", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);
        end
        fetch_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); check_out("stall", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);
        end
        stall = 1'b0;
        tick(); check_out("release", 32'h14, 1'b1, 1'b0, 1'b0, 32'd5);

        exc_req = 1'b1; jmp_en = 1'b1; jmp_target = 32'h200;
        br_taken = 1'b1; br_target = 32'h300;
        tick(); check_out("prio", 32'h100, 1'b0, 1'b1, 1'b0, 32'd6);
        exc_req = 1'b0; jmp_en = 1'b0; br_taken = 1'b0;
        tick(); check_out("prio_bub", 32'h100, 1'b1, 1'b0, 1'b0, 32'd6);
        tick(); check_out("prio_acc", 32'h104, 1'b1, 1'b0, 1'b0, 32'd7);

        stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        tick(); check_out("br_stall", 32'h40, 1'b0, 1'b1, 1'b0, 32'd7);
        stall = 1'b0; br_taken = 1'b0; jmp_en = 1'b1; jmp_target = 32'h80;
        tick(); check_out("jmp_bub", 32'h80, 1'b0, 1'b1, 1'b0, 32'd7);
        jmp_en = 1'b0;
        tick(); check_out("resume", 32'h80, 1'b1, 1'b0, 1'b0, 32'd7);
        tick(); check_out("resume_acc", 32'h84, 1'b1, 1'b0, 1'b0, 32'd8);

        jmp_en = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick(); check_out("jmp_top", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'd9);
        jmp_en = 1'b0;
        tick(); check_out("top_bub", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd9);
        tick(); check_out("pc_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 32'd10);

        fetch_ready = 1'b0;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        fetch_ready = 1'b1;
        tick(); check_out("cnt_wrap", 32'h4, 1'b1, 1'b0, 1'b0, 32'd0);

        br_taken = 1'b1; br_target = 32'h42;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check_out("align", 32'h100, 1'b0, 1'b1, 1'b1, 32'd1);
`else
        check_out("align", 32'h40, 1'b0, 1'b1, 1'b0, 32'd1);
`endif
        br_taken = 1'b0;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check_out("align_bub", 32'h100, 1'b1, 1'b0, 1'b0, 32'd1);
`else
        check_out("align_bub", 32'h40, 1'b1, 1'b0, 1'b0, 32'd1);
`endif

        br_taken = 1'b1; br_target = 32'h200;
        tick(); check_out("pre_rst", 32'h200, 1'b0, 1'b1, 1'b0, 32'd2);
        rst = 1'b1; br_taken = 1'b0; jmp_en = 1'b1; jmp_target = 32'h500;
        tick(); check_out("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0; jmp_en = 1'b0;
        tick(); check_out("post_rst", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
